// File: rtl/router_reg.sv
// Datapath register stage of the 1x3 router: header latch, output byte steering,
// full-FIFO hold/replay and running parity check, all driven by FSM state strobes.
module router_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  detect_addr,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  rst_int_reg,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  low_pkt_valid,
    output logic                  parity_done,
    output logic                  err
);

    logic [DATA_WIDTH-1:0] header;
    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] int_parity;
    logic [DATA_WIDTH-1:0] pkt_parity;

    // Address 3 does not exist on a 1x3 router, so such a header is never captured.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            header <= '0;
        end else if (detect_addr && pkt_valid && (data_in[1:0] != 2'b11)) begin
            header <= data_in;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dout <= '0;
            hold <= '0;
        end else if (lfd_state) begin
            dout <= header;
        end else if (ld_state && !fifo_full) begin
            dout <= data_in;
        end else if (ld_state && fifo_full) begin
            hold <= data_in;
        end else if (laf_state) begin
            dout <= hold;
        end
    end

    // The parity byte itself is captured separately and never folded into the running XOR.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            int_parity <= '0;
            pkt_parity <= '0;
        end else if (detect_addr) begin
            int_parity <= '0;
            pkt_parity <= '0;
        end else begin
            if (lfd_state) begin
                int_parity <= int_parity ^ header;
            end else if (ld_state && pkt_valid && !full_state) begin
                int_parity <= int_parity ^ data_in;
            end
            if (ld_state && !pkt_valid) begin
                pkt_parity <= data_in;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            low_pkt_valid <= 1'b0;
        end else if (rst_int_reg) begin
            low_pkt_valid <= 1'b0;
        end else if (ld_state && !pkt_valid) begin
            low_pkt_valid <= 1'b1;
        end
    end

    // A parity byte stalled by a full FIFO only counts as forwarded once replayed from hold.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            parity_done <= 1'b0;
        end else if (detect_addr) begin
            parity_done <= 1'b0;
        end else if ((ld_state && !fifo_full && !pkt_valid) ||
                     (laf_state && low_pkt_valid && !parity_done)) begin
            parity_done <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            err <= 1'b0;
        end else if (detect_addr) begin
            err <= 1'b0;
        end else if (parity_done) begin
            err <= (int_parity != pkt_parity);
        end
    end

endmodule
